ha_array_accum: RTL and testbench

- Downstream consumer of the 8x8 unsigned approximate multiplier's half-adder partial-product stage.
- Takes the four ha_array row pairs (b[6:0], t[8:0]) and reduces them to a 16-bit product.
- Iterative: captures all rows on a valid/ready handshake, accumulates one row per cycle, then presents the product with a valid/ready output handshake.
- Sits between the combinational ha_array stage and the product consumer or register file.

---
 rtl/ha_array_pkg.sv | 30 +++
 rtl/ha_row_weight.sv | 14 +
 rtl/ha_array_accum.sv | 98 +++++++++
 tb/tb_ha_array_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ha_array_pkg.sv
// Shared constants, types and the row-value helper for the half-adder
// partial-product accumulator of the 8x8 approximate multiplier.
package ha_array_pkg;

   localparam int NUM_ROWS = 4;
   localparam int B_W      = 7;
   localparam int T_W      = 9;
   localparam int PROD_W   = 16;
   localparam int ACC_W    = 17;
   localparam int CNT_W    = $clog2(NUM_ROWS);
   localparam int ROW_W    = T_W + 2;  // t + (b << 2) never exceeds 1019

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_e;

   // One ha_array row pair: carry-type bits b and sum-type bits t.
   typedef struct packed {
      logic [B_W-1:0] b;
      logic [T_W-1:0] t;
   } row_t;

   // t bit j weighs 2^j, b bit j weighs 2^(j+2).
   function automatic logic [ROW_W-1:0] row_value(input row_t r);
      return ROW_W'(r.t) + (ROW_W'(r.b) << 2);
   endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational weighting of a single row: row_value(row) << 2k.
module ha_row_weight
   import ha_array_pkg::*;
(
   input  row_t             row,
   input  logic [CNT_W-1:0] k,
   output logic [ACC_W-1:0] weighted
);

   // Row k carries weight 4^k, i.e. a left shift by 2k.
   // NOTE: a continuous assign is pure combinational logic, so no latch can form here.
   assign weighted = ACC_W'(row_value(row)) << {k, 1'b0};

endmodule

// File: rtl/ha_array_accum.sv
// Iterative reduction of the four ha_array row pairs into a 16-bit product.
// Rows are captured on the input handshake, summed one per cycle, and the
// result is held until the consumer takes it.
module ha_array_accum
   import ha_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [B_W-1:0]    ha_array_0_b,
   input  logic [B_W-1:0]    ha_array_1_b,
   input  logic [B_W-1:0]    ha_array_2_b,
   input  logic [B_W-1:0]    ha_array_3_b,
   input  logic [T_W-1:0]    ha_array_0_t,
   input  logic [T_W-1:0]    ha_array_1_t,
   input  logic [T_W-1:0]    ha_array_2_t,
   input  logic [T_W-1:0]    ha_array_3_t,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              overflow
);

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   weighted;
   logic [ACC_W-1:0]   acc_next;
   row_t               rows [NUM_ROWS];

   wire accept = (state == IDLE) && in_valid;

   // Capture all row pairs on the accept edge; later input changes are ignored.
   // NOTE: the row registers are pure datapath qualified by the FSM, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         rows[0] <= {ha_array_0_b, ha_array_0_t};
         rows[1] <= {ha_array_1_b, ha_array_1_t};
         rows[2] <= {ha_array_2_b, ha_array_2_t};
         rows[3] <= {ha_array_3_b, ha_array_3_t};
      end
   end

   ha_row_weight u_row_weight (
      .row      (rows[cnt]),
      .k        (cnt),
      .weighted (weighted)
   );

   assign acc_next = acc + weighted;

   // Handshake FSM with counter, accumulator and registered outputs.
   // NOTE: every state element here uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ACC;
               end
            end
            ACC: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;  // wraps to 0 after the last row
               if (cnt == CNT_W'(NUM_ROWS - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  product   <= acc_next[PROD_W-1:0];
                  overflow  <= |acc_next[ACC_W-1:PROD_W];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ha_array_accum.sv
// Scoreboard bench for ha_array_accum: expected products are queued on each
// input handshake and compared on each output handshake.
module tb_ha_array_accum;
   import ha_array_pkg::*;

   typedef struct packed {
      logic [15:0] prod;
      logic        ovf;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        b_in [4];
   logic [8:0]        t_in [4];
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       product;
   logic              overflow;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_acc = -1;
   bit   b2b      = 1'b0;
   int   n_acc    = 0;
   exp_t sb [$];

   always #5 clk = ~clk;

   ha_array_accum dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (b_in[0]),
      .ha_array_1_b (b_in[1]),
      .ha_array_2_b (b_in[2]),
      .ha_array_3_b (b_in[3]),
      .ha_array_0_t (t_in[0]),
      .ha_array_1_t (t_in[1]),
      .ha_array_2_t (t_in[2]),
      .ha_array_3_t (t_in[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .overflow     (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Golden weighted sum: sum_k (t_k + 4*b_k) * 4^k.
   function automatic logic [16:0] model_sum();
      logic [16:0] s;
      s = '0;
      for (int k = 0; k < 4; k++)
         s = s + ((17'(t_in[k]) + 17'(b_in[k]) * 17'd4) * (17'd1 << (2 * k)));
      return s;
   endfunction

   // Resolve handshakes seen on current values, then advance one clock.
   task automatic tick();
      exp_t e;
      logic [16:0] s;
      if (in_valid && in_ready) begin
         s = model_sum();
         e.prod = s[15:0];
         e.ovf  = s[16];
         sb.push_back(e);
         n_acc++;
         if (b2b && last_acc >= 0) check("b2b_spacing", cyc - last_acc, 6);
         last_acc = cyc;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = sb.pop_front();
            check("product", product, e.prod);
            check("overflow", overflow, e.ovf);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_rows(input logic [6:0] b0, b1, b2, b3,
                           input logic [8:0] t0, t1, t2, t3);
      b_in[0] = b0; b_in[1] = b1; b_in[2] = b2; b_in[3] = b3;
      t_in[0] = t0; t_in[1] = t1; t_in[2] = t2; t_in[3] = t3;
   endtask

   task automatic randomize_rows();
      for (int k = 0; k < 4; k++) begin
         b_in[k] = 7'($urandom_range(0, 127));
         t_in[k] = 9'($urandom_range(0, 511));
      end
   endtask

   // Accept the current row set, measure latency, then take the product.
   task automatic run_one(input string tag);
      int edges;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
      end
      check({tag, "_latency"}, edges, 5);
      check({tag, "_out_valid"}, out_valid, 1);
      out_ready = 1'b1;
      tick();
      check({tag, "_in_ready_after"}, in_ready, 1);
      check({tag, "_out_valid_after"}, out_valid, 0);
   endtask

   initial begin
      logic [15:0] held_p;
      logic        held_o;
      int          budget;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_rows(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of accumulation aborts with no output.
      set_rows(7'h11, 7'h22, 7'h33, 7'h44, 9'h055, 9'h066, 9'h077, 9'h088);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_product", product, 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_one("post_reset");

      // Single LSB.
      set_rows(0, 0, 0, 0, 9'h001, 0, 0, 0);
      run_one("t0_one");

      // Top b bit of row 3: 256 << 6.
      set_rows(0, 0, 0, 7'h40, 0, 0, 0, 0);
      check("b3_model", model_sum(), 17'd16384);
      run_one("b3_msb");

      // All ones: 86615, overflows 16 bits.
      set_rows(7'h7F, 7'h7F, 7'h7F, 7'h7F, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
      check("max_model", model_sum(), 17'd86615);
      run_one("all_ones");

      // Backpressure with toggling inputs.
      randomize_rows();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      budget = 0;
      while (!out_valid && budget < 20) begin
         randomize_rows();
         tick();
         budget++;
      end
      check("bp_out_valid", out_valid, 1);
      held_p = product;
      held_o = overflow;
      for (int i = 0; i < 10; i++) begin
         randomize_rows();
         in_valid = 1'(i % 2);
         tick();
         check("bp_product_stable", product, held_p);
         check("bp_overflow_stable", overflow, held_o);
         check("bp_out_valid_stable", out_valid, 1);
         check("bp_in_ready_low", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_released_out_valid", out_valid, 0);
      check("bp_released_in_ready", in_ready, 1);
      check("bp_sb_empty", sb.size(), 0);

      // Back-to-back random traffic.
      b2b      = 1'b1;
      last_acc = -1;
      n_acc    = 0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      set_rows(7'h7F, 7'h7F, 7'h7F, 7'h7F, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
      budget = 0;
      while (n_acc < 1000 && budget < 7000) begin
         tick();
         randomize_rows();
         budget++;
      end
      check("b2b_accepted", n_acc, 1000);
      b2b      = 1'b0;
      in_valid = 1'b0;
      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
         tick();
         budget++;
      end
      check("b2b_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
